// File: rtl/crc_ser_pkg.sv
// Shared types and sizing helpers for the CRC-24 bit serializer.
// Bit order is selected by CRC_SER_LSB_FIRST_EN (defined: LSB first, default: MSB first).
package crc_ser_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } crc_ser_state_e;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned CRC_W_DEF   = 24;
    localparam int unsigned CRC_LAT_DEF = 1;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crc_ser_shreg.sv
// Load/shift register feeding the serial bit stream; direction set by CRC_SER_LSB_FIRST_EN.
// next_bit_c is the bit that leaves on this cycle's shift, including a word loaded this cycle.
module crc_ser_shreg
    import crc_ser_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              next_bit_c
);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [DATA_W-1:0] src_c;

    // A load and a shift in the same cycle emit the new word's first bit immediately.
    always_comb begin
        src_c   = load_i ? data_i : shreg_q;
        shreg_d = src_c;
`ifdef CRC_SER_LSB_FIRST_EN
        next_bit_c = src_c[0];
        if (shift_i) begin
            shreg_d = {1'b0, src_c[DATA_W-1:1]};
        end
`else
        next_bit_c = src_c[DATA_W-1];
        if (shift_i) begin
            shreg_d = {src_c[DATA_W-2:0], 1'b0};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/crc_bit_serializer.sv
// Streams parallel words bit-serially into a CRC-24 engine, framing and capturing the result.
// CRC_SER_LSB_FIRST_EN selects LSB-first shifting; undefined shifts MSB first.
module crc_bit_serializer
    import crc_ser_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned CRC_W   = CRC_W_DEF,
    parameter int unsigned CRC_LAT = CRC_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              crc_init,
    output logic              data_in,
    output logic              enb,
    input  logic [CRC_W-1:0]  crc,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid,
    input  logic              crc_ready
);

    localparam int unsigned BIT_CNT_W = cnt_w(DATA_W);
    localparam int unsigned LAT_CNT_W = cnt_w(CRC_LAT);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);
    localparam logic [LAT_CNT_W-1:0] LAST_LAT = LAT_CNT_W'(CRC_LAT - 1);

    crc_ser_state_e        state_q,     state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [LAT_CNT_W-1:0]  lat_cnt_q,   lat_cnt_d;
    logic                  last_q,      last_d;
    logic                  s_ready_q,   s_ready_d;
    logic                  crc_init_q,  crc_init_d;
    logic                  data_in_q,   data_in_d;
    logic                  enb_q,       enb_d;
    logic [CRC_W-1:0]      crc_out_q,   crc_out_d;
    logic                  crc_valid_q, crc_valid_d;

    logic sh_load_c;
    logic sh_shift_c;
    logic sh_bit_c;
    logic xfer_c;

    assign xfer_c = s_valid & s_ready_q;

    crc_ser_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (sh_load_c),
        .shift_i    (sh_shift_c),
        .data_i     (s_data),
        .next_bit_c (sh_bit_c)
    );

    // Next-state and next-output logic; every output flop is loaded with its value for the next cycle.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        last_d      = last_q;
        crc_out_d   = crc_out_q;
        crc_valid_d = crc_valid_q;
        s_ready_d   = 1'b0;
        crc_init_d  = 1'b0;
        data_in_d   = 1'b0;
        enb_d       = 1'b0;
        sh_load_c   = 1'b0;
        sh_shift_c  = 1'b0;

        case (state_q)
            IDLE: begin
                s_ready_d = 1'b1;
                if (xfer_c) begin
                    sh_load_c  = 1'b1;
                    last_d     = s_last;
                    crc_init_d = 1'b1;
                    s_ready_d  = 1'b0;
                    state_d    = INIT;
                end
            end
            INIT: begin
                sh_shift_c = 1'b1;
                enb_d      = 1'b1;
                data_in_d  = sh_bit_c;
                bit_cnt_d  = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt_q != LAST_BIT) begin
                    sh_shift_c = 1'b1;
                    enb_d      = 1'b1;
                    data_in_d  = sh_bit_c;
                    bit_cnt_d  = BIT_CNT_W'(bit_cnt_q + 1'b1);
                    s_ready_d  = (bit_cnt_d == LAST_BIT) && !last_q;
                end else if (last_q) begin
                    lat_cnt_d = '0;
                    state_d   = WAIT;
                end else if (xfer_c) begin
                    // Reload on the boundary so the next word's first bit follows without a gap.
                    sh_load_c  = 1'b1;
                    sh_shift_c = 1'b1;
                    last_d     = s_last;
                    enb_d      = 1'b1;
                    data_in_d  = sh_bit_c;
                    bit_cnt_d  = '0;
                end else begin
                    s_ready_d = 1'b1;
                end
            end
            WAIT: begin
                if (lat_cnt_q == LAST_LAT) begin
                    crc_out_d   = crc;
                    crc_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    lat_cnt_d = LAT_CNT_W'(lat_cnt_q + 1'b1);
                end
            end
            DONE: begin
                if (crc_ready) begin
                    crc_valid_d = 1'b0;
                    s_ready_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            last_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            crc_init_q  <= 1'b0;
            data_in_q   <= 1'b0;
            enb_q       <= 1'b0;
            crc_out_q   <= '0;
            crc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            last_q      <= last_d;
            s_ready_q   <= s_ready_d;
            crc_init_q  <= crc_init_d;
            data_in_q   <= data_in_d;
            enb_q       <= enb_d;
            crc_out_q   <= crc_out_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign crc_init  = crc_init_q;
    assign data_in   = data_in_q;
    assign enb       = enb_q;
    assign crc_out   = crc_out_q;
    assign crc_valid = crc_valid_q;

endmodule

// File: tb/tb_crc_bit_serializer.sv
// Self-checking bench for crc_bit_serializer with a behavioural CRC-24 engine and stream model.
module tb_crc_bit_serializer;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CRC_W   = 24;
    localparam int unsigned CRC_LAT = 1;
    localparam logic [23:0] POLY    = 24'h864CFB;
    localparam logic [23:0] INIT_V  = 24'hB704CE;
`ifdef CRC_SER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic              crc_init;
    logic              data_in;
    logic              enb;
    logic [CRC_W-1:0]  crc;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_valid;
    logic              crc_ready;

    int checks   = 0;
    int failures = 0;

    crc_bit_serializer #(
        .DATA_W  (DATA_W),
        .CRC_W   (CRC_W),
        .CRC_LAT (CRC_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .crc_init  (crc_init),
        .data_in   (data_in),
        .enb       (enb),
        .crc       (crc),
        .crc_out   (crc_out),
        .crc_valid (crc_valid),
        .crc_ready (crc_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b);
        return {c[22:0], 1'b0} ^ (((c[23] ^ b) == 1'b1) ? POLY : 24'h0);
    endfunction

    function automatic logic [23:0] crc_words(input logic [7:0] w[$], input bit lsb);
        logic [23:0] c;
        c = INIT_V;
        foreach (w[k]) begin
            for (int i = 0; i < 8; i++) begin
                c = crc_step(c, lsb ? w[k][i] : w[k][7-i]);
            end
        end
        return c;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Engine stand-in: one-cycle latency serial CRC-24.
    logic [23:0] eng;
    always @(posedge clk or negedge rst) begin
        if (!rst)          eng <= 24'h0;
        else if (crc_init) eng <= INIT_V;
        else if (enb)      eng <= crc_step(eng, data_in);
    end
    assign crc = eng;

    // Stream model state.
    bit         exp_bits[$];
    logic [7:0] frame_words[$];
    bit         frame_act, last_acc, vld_prev, rdy_prev;
    int         cyc = 0, since_rst = 0, xfer_cyc = 0, init_cyc = 0, last_enb_cyc = 0;
    int         bits_in_frame, run, max_run, rdy_in_frame, gaps, frames_done = 0;
    logic [7:0] seq8;
    logic [23:0] hold_v, last_crc, expc;
    bit         exp_r, b;

    always @(negedge clk) begin
        if (!rst) begin
            exp_bits.delete();
            frame_words.delete();
            frame_act = 0; last_acc = 0; vld_prev = 0; rdy_prev = 0;
            bits_in_frame = 0; run = 0; since_rst = 0;
        end else begin
            if (crc_init) begin
                chk(!enb && frame_act && bits_in_frame == 0, "init_pulse", 32'(enb), 32'(0));
                chk(cyc == xfer_cyc + 1, "init_latency", 32'(cyc - xfer_cyc), 32'(1));
                init_cyc = cyc;
            end
            if (enb) begin
                if (exp_bits.size() == 0) begin
                    chk(1'b0, "bit_underrun", 32'(1), 32'(0));
                end else begin
                    b = exp_bits.pop_front();
                    chk(data_in == b, "data_in", 32'(data_in), 32'(b));
                end
                bits_in_frame++;
                run++;
                if (run > max_run) max_run = run;
                last_enb_cyc = cyc;
                if (bits_in_frame <= 8) seq8 = {seq8[6:0], data_in};
                if (bits_in_frame == 1)
                    chk(cyc == init_cyc + 1, "first_bit_lat", 32'(cyc - init_cyc), 32'(1));
            end else begin
                run = 0;
                if (frame_act && !crc_init && !last_acc) gaps++;
            end
            if (!frame_act) exp_r = (since_rst > 0);
            else            exp_r = (exp_bits.size() == 0) && !last_acc;
            chk(s_ready == exp_r, "s_ready", 32'(s_ready), 32'(exp_r));
            if (frame_act && s_ready) rdy_in_frame++;
            if (crc_valid && !vld_prev) begin
                chk(frame_act && last_acc && exp_bits.size() == 0, "crc_rise_state", 32'(1), 32'(0));
                chk(cyc == last_enb_cyc + CRC_LAT + 1, "crc_latency", 32'(cyc - last_enb_cyc), 32'(CRC_LAT + 1));
                expc = crc_words(frame_words, LSB);
                chk(crc_out == expc, "crc_out", 32'(crc_out), 32'(expc));
                hold_v = crc_out;
                last_crc = crc_out;
                frames_done++;
            end else if (crc_valid) begin
                chk(crc_out == hold_v, "crc_hold", 32'(crc_out), 32'(hold_v));
            end
            if (vld_prev) chk(crc_valid == !rdy_prev, "crc_valid_hs", 32'(crc_valid), 32'(!rdy_prev));
            if (crc_valid && crc_ready) frame_act = 0;
            if (s_valid && s_ready) begin
                if (!frame_act) begin
                    frame_act = 1; last_acc = 0; frame_words.delete();
                    bits_in_frame = 0; max_run = 0; rdy_in_frame = 0; gaps = 0; seq8 = 8'h0;
                    xfer_cyc = cyc;
                end
                frame_words.push_back(s_data);
                for (int i = 0; i < 8; i++) exp_bits.push_back(LSB ? s_data[i] : s_data[7-i]);
                if (s_last) last_acc = 1;
            end
            vld_prev = crc_valid;
            rdy_prev = crc_ready;
            since_rst++;
        end
        cyc++;
    end

    task automatic send_word(input logic [7:0] d, input logic l, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1; s_data = d; s_last = l;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 200) begin @(negedge clk); n++; end
        if (!s_ready) chk(1'b0, "send_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!crc_valid && n < 400) begin @(posedge clk); #1; n++; end
        chk(crc_valid, "crc_valid_wait", 32'(crc_valid), 32'(1));
    endtask

    task automatic ack();
        crc_ready = 1'b1;
        @(posedge clk); #1;
        crc_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(s_ready == 0,   {tag, "_s_ready"},   32'(s_ready),   32'(0));
        chk(crc_init == 0,  {tag, "_crc_init"},  32'(crc_init),  32'(0));
        chk(data_in == 0,   {tag, "_data_in"},   32'(data_in),   32'(0));
        chk(enb == 0,       {tag, "_enb"},       32'(enb),       32'(0));
        chk(crc_out == 0,   {tag, "_crc_out"},   32'(crc_out),   32'(0));
        chk(crc_valid == 0, {tag, "_crc_valid"}, 32'(crc_valid), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] wq[$];
        logic [23:0] ref_crc;
        int fd0, nw;

        rst = 1'b0; s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0; crc_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        // Model pin: CRC-24/OpenPGP check value of "123456789".
        wq.delete();
        for (int i = 0; i < 9; i++) wq.push_back(8'(8'h31 + i));
        ref_crc = crc_words(wq, 1'b0);
        chk(ref_crc == 24'h21CF02, "model_pin", 32'(ref_crc), 32'h21CF02);

        // Single word 0xA5.
        fd0 = frames_done;
        send_word(8'hA5, 1'b1, 0);
        wait_valid();
        ack();
        chk(seq8 == 8'hA5, "a5_bits", 32'(seq8), 32'hA5);
        wq.delete(); wq.push_back(8'hA5);
        ref_crc = crc_words(wq, LSB);
        chk(last_crc == ref_crc, "a5_crc", 32'(last_crc), 32'(ref_crc));
        chk(frames_done == fd0 + 1, "a5_frames", 32'(frames_done - fd0), 32'(1));

        // Three words back to back.
        send_word(8'h12, 1'b0, 0);
        send_word(8'h34, 1'b0, 0);
        send_word(8'h56, 1'b1, 0);
        wait_valid();
        ack();
        chk(max_run == 24, "burst_run", 32'(max_run), 32'(24));
        chk(rdy_in_frame == 2, "burst_ready", 32'(rdy_in_frame), 32'(2));

        // Second word late: five bubble cycles, same CRC as gap-free 0x12,0x34.
        send_word(8'h12, 1'b0, 0);
        send_word(8'h34, 1'b1, 13);
        wait_valid();
        ack();
        chk(gaps == 5, "gap_bubbles", 32'(gaps), 32'(5));
        chk(max_run == 8, "gap_run", 32'(max_run), 32'(8));
        wq.delete(); wq.push_back(8'h12); wq.push_back(8'h34);
        ref_crc = crc_words(wq, LSB);
        chk(last_crc == ref_crc, "gap_crc", 32'(last_crc), 32'(ref_crc));

        // Result held while consumer stalls.
        send_word(8'h5A, 1'b1, 0);
        wait_valid();
        s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk(crc_valid == 1, "stall_valid", 32'(crc_valid), 32'(1));
        chk(s_ready == 0, "stall_ready", 32'(s_ready), 32'(0));
        s_valid = 1'b0;
        wq.delete(); wq.push_back(8'h5A);
        ref_crc = crc_words(wq, LSB);
        chk(crc_out == ref_crc, "stall_crc", 32'(crc_out), 32'(ref_crc));
        ack();

        // Reset in the middle of word 2, then a clean 0xFF frame.
        send_word(8'h11, 1'b0, 0);
        send_word(8'h22, 1'b1, 0);
        repeat (4) begin @(posedge clk); #1; end
        chk(enb == 1, "pre_rst_enb", 32'(enb), 32'(1));
        fd0 = frames_done;
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        send_word(8'hFF, 1'b1, 0);
        wait_valid();
        ack();
        wq.delete(); wq.push_back(8'hFF);
        ref_crc = crc_words(wq, LSB);
        chk(last_crc == ref_crc, "post_rst_crc", 32'(last_crc), 32'(ref_crc));
        chk(frames_done == fd0 + 1, "post_rst_frames", 32'(frames_done - fd0), 32'(1));

        // Bit order.
        send_word(8'h01, 1'b1, 0);
        wait_valid();
        ack();
        chk(seq8 == (LSB ? 8'h80 : 8'h01), "bit_order", 32'(seq8), LSB ? 32'h80 : 32'h01);

        // Randomized frames, gaps and consumer stalls.
        for (int f = 0; f < 25; f++) begin
            nw = int'($urandom_range(1, 4));
            for (int w = 0; w < nw; w++)
                send_word(8'($urandom), 1'(w == nw - 1), int'($urandom_range(0, 3)));
            wait_valid();
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            ack();
        end
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
